// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared types and defaults for the instruction loader
package instr_loader_pkg;

  localparam int DEFAULT_DEPTH  = 512;
  localparam int DEFAULT_ADDR_W = 9;
  localparam int WORD_W         = 16;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA_HI,
    DATA_LO,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/instr_mem_512x16.sv
// rtl/instr_mem_512x16.sv - instruction store, one sync write port, one registered read port
module instr_mem_512x16
  import instr_loader_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WORD_W-1:0] rd_data_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read samples the array before this edge's write lands: same-address read returns old data.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - parses a length-prefixed byte stream into instruction memory
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_e            state_q, state_d;
  logic [15:0]       word_count_q, word_count_d;
  logic [7:0]        hi_byte_q, hi_byte_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
  logic              mem_we;
  logic [15:0]       hdr_count;
  logic [ADDR_W:0]   wl_inc;

  assign hdr_count = {word_count_q[15:8], in_data};
  assign wl_inc    = words_loaded_q + (ADDR_W+1)'(1);

  always_comb begin
    state_d        = state_q;
    word_count_d   = word_count_q;
    hi_byte_d      = hi_byte_q;
    wr_ptr_d       = wr_ptr_q;
    words_loaded_d = words_loaded_q;
    mem_we         = 1'b0;
    in_ready       = 1'b0;
    case (state_q)
      HDR_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_count_d = {in_data, word_count_q[7:0]};
          state_d      = HDR_LO;
        end
      end
      HDR_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_count_d = hdr_count;
          if (hdr_count == 16'd0 || hdr_count > DEPTH_W) begin
            state_d = ERR;
          end else begin
            state_d = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hi_byte_d = in_data;
          state_d   = DATA_LO;
        end
      end
      DATA_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we         = 1'b1;
          words_loaded_d = wl_inc;
          // Pointer stops on the final word so a full-depth load never wraps it.
          if (16'(wl_inc) == word_count_q) begin
            state_d = DONE;
          end else begin
            wr_ptr_d = wr_ptr_q + (ADDR_W)'(1);
            state_d  = DATA_HI;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= HDR_HI;
      word_count_q   <= '0;
      hi_byte_q      <= '0;
      wr_ptr_q       <= '0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      word_count_q   <= word_count_d;
      hi_byte_q      <= hi_byte_d;
      wr_ptr_q       <= wr_ptr_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  instr_mem_512x16 #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i     (clock),
    .rst_n_i   (reset_n),
    .we_i      (mem_we & reset_n),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i ({hi_byte_q, in_data}),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign load_done    = (state_q == DONE);
  assign load_err     = (state_q == ERR);
  assign words_loaded = words_loaded_q;

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter DEPTH, default 512, number of 16-bit instruction words held.
REQ-002 Parameter ADDR_W, default 9, read-address width; SHALL equal clog2(DEPTH).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  byte-stream valid from host.
REQ-006 in_data  input  8  byte-stream data.
REQ-007 in_ready  output  1  loader can accept a byte this cycle.
REQ-008 rd_addr  input  ADDR_W  CPU fetch address (PC[ADDR_W-1:0]).
REQ-009 rd_data  output  16  fetched instruction word.
REQ-010 load_done  output  1  program fully loaded; CPU may run.
REQ-011 load_err  output  1  header rejected; load aborted.
REQ-012 words_loaded  output  ADDR_W+1  count of words written this load.

Function
REQ-013 Byte accepted only on a rising edge with in_valid=1 and in_ready=1; in_data ignored otherwise.
REQ-014 FSM states: HDR_HI, HDR_LO, DATA_HI, DATA_LO, DONE, ERR.
REQ-015 in_ready SHALL be 1 in HDR_HI/HDR_LO/DATA_HI/DATA_LO and 0 in DONE/ERR, decoded from state only (no dependence on in_valid).
REQ-016 HDR_HI: accepted byte -> word_count[15:8]; go HDR_LO.
REQ-017 HDR_LO: accepted byte -> word_count[7:0]; if resulting count = 0 or > DEPTH go ERR, else go DATA_HI.
REQ-018 DATA_HI: accepted byte held as high byte; go DATA_LO.
REQ-019 DATA_LO: accepted byte forms word {high, byte}, written to mem[wr_ptr] on that edge; wr_ptr and words_loaded increment by 1.
REQ-020 After the DATA_LO write, go DONE if incremented words_loaded = word_count, else DATA_HI.
REQ-021 No accepted byte -> state and counters hold (bubbles anywhere are legal).
REQ-022 DONE and ERR are sticky until reset; further in_valid ignored.
REQ-023 load_done = 1 exactly in DONE, load_err = 1 exactly in ERR; both registered state decodes, first high the cycle after the final accepted byte.
REQ-024 rd_data <= mem[rd_addr] every rising edge, one-cycle latency, in all states including during load.
REQ-025 Read and write to same address on same edge: rd_data returns the old contents.
REQ-026 Unwritten locations return undefined contents; the CPU SHALL gate fetch on load_done.
REQ-027 words_loaded never exceeds DEPTH; wr_ptr never wraps.

Reset
REQ-028 reset_n=0 at a rising edge: state HDR_HI, word_count 0, wr_ptr 0, words_loaded 0, rd_data 0, load_done 0, load_err 0; in_ready thus 1 after reset.
REQ-029 Reset mid-load discards the partial load (counters to 0, held high byte dropped); memory contents are not cleared.
REQ-030 Reset dominates any simultaneous byte acceptance; that byte is not captured.

Structure
REQ-031 Package instr_loader_pkg SHALL hold the FSM state enum, DEPTH and ADDR_W defaults, and the 16-bit word width constant.
REQ-032 Storage SHALL be sub-module instr_mem_512x16: one synchronous write port, one registered read port, no reset on the array.
REQ-033 Header parsing, FSM and counters SHALL live in instr_loader itself.

Verification
REQ-034 Bytes 00 03 12 34 AB CD 00 FF, in_valid held 1 -> mem[0]=1234, mem[1]=ABCD, mem[2]=00FF; load_done=1 the cycle after byte 8; words_loaded=3; in_ready=0.
REQ-035 Header 00 00 -> load_err=1 the cycle after byte 2, in_ready=0; a following byte 55 is ignored and words_loaded stays 0.
REQ-036 Header 02 01 (513) -> load_err=1; header 02 00 plus 1024 bytes -> load_done=1, words_loaded=512, mem[511] equals the last byte pair.
REQ-037 Same stream as REQ-034 with in_valid randomly deasserted 50% of cycles -> identical memory contents and words_loaded=3.
REQ-038 reset_n=0 after bytes 00 02 12 accepted -> words_loaded=0, state HDR_HI; new stream 00 01 BE EF -> mem[0]=BEEF, load_done=1.
REQ-039 rd_addr=0 held while writing mem[0]=1234 over prior value ABCD -> rd_data=ABCD on the write edge, 1234 on the next edge.
